// File: rtl/wasca_led_sequencer.sv
// wasca_led_sequencer
//   Avalon-MM slave LED pattern sequencer. Steps through up to four LED
//   patterns (PAT0..PAT3), holding each step for PERIOD+1 clocks. The
//   sequence can loop or stop after the last step (ONESHOT). When the
//   sequencer is idle, the LEDs show the STATIC pattern.
//
//   Register map (word address):
//     0 CTRL   {[3:2] LAST, [1] ONESHOT, [0] EN}       rw
//     1 PERIOD [23:0]                                  rw
//     2 STATIC [LED_WIDTH-1:0]                         rw
//     3..6 PAT0..PAT3 [LED_WIDTH-1:0]                  rw
//     7 STATUS {[3] DONE, [2] RUNNING, [1:0] STEP}     ro (writing bit 3 clears DONE)
//
// Ports
//   clk        sole clock, rising edge
//   reset      asynchronous, active-high
//   address    word address
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   combinational read data, zero-extended
//   out_port   registered LED drive
module wasca_led_sequencer #(
  parameter int LED_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic [LED_WIDTH-1:0] out_port
);

  typedef struct packed {
    logic [1:0] last;
    logic       oneshot;
    logic       en;
  } ctrl_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                      state;
  ctrl_t                       ctrl;
  logic [23:0]                 period;
  logic [LED_WIDTH-1:0]        static_r;
  logic [3:0][LED_WIDTH-1:0]   pat;
  logic                        done;
  logic [1:0]                  step;
  logic [23:0]                 counter;

  logic wr, ctrl_wr, stat_clr;
  assign wr       = chipselect && !write_n;
  assign ctrl_wr  = wr && (address == 3'd0);
  assign stat_clr = wr && (address == 3'd7) && writedata[3];

  // Upper write-data bits have no home in any register.
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:24];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      ctrl     <= '0;
      period   <= '0;
      static_r <= '0;
      pat      <= '0;
      done     <= 1'b0;
      step     <= '0;
      counter  <= '0;
      out_port <= '0;
    end else begin
      // Register file
      if (wr) begin
        case (address)
          3'd0: ctrl     <= writedata[3:0];
          3'd1: period   <= writedata[23:0];
          3'd2: static_r <= writedata[LED_WIDTH-1:0];
          3'd3: pat[0]   <= writedata[LED_WIDTH-1:0];
          3'd4: pat[1]   <= writedata[LED_WIDTH-1:0];
          3'd5: pat[2]   <= writedata[LED_WIDTH-1:0];
          3'd6: pat[3]   <= writedata[LED_WIDTH-1:0];
          default: ;
        endcase
      end

      // LED drive lags state/step by one clock; reads the live registers
      // so pattern/static writes show up one clock after the write edge.
      if (state == S_IDLE) out_port <= static_r;
      else                 out_port <= pat[step];

      // Sequencer. A CTRL write overrides any step boundary in the same cycle.
      if (ctrl_wr) begin
        step    <= '0;
        counter <= '0;
        if (writedata[0]) begin
          state <= S_RUN;
          done  <= 1'b0;
        end else begin
          state <= S_IDLE;
        end
      end else begin
        if (stat_clr) done <= 1'b0;
        // >= compares make shrinking PERIOD/LAST mid-run take effect at once.
        if (state == S_RUN) begin
          if (counter >= period) begin
            counter <= '0;
            if (step >= ctrl.last) begin
              if (ctrl.oneshot) begin
                state <= S_DONE;
                done  <= 1'b1; // later assignment: set beats a coincident clear
              end else begin
                step <= '0;
              end
            end else begin
              step <= step + 2'd1;
            end
          end else begin
            counter <= counter + 24'd1;
          end
        end
      end
    end
  end

  // Combinational, side-effect-free read mux.
  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata[3:0]           = ctrl;
      3'd1: readdata[23:0]          = period;
      3'd2: readdata[LED_WIDTH-1:0] = static_r;
      3'd3: readdata[LED_WIDTH-1:0] = pat[0];
      3'd4: readdata[LED_WIDTH-1:0] = pat[1];
      3'd5: readdata[LED_WIDTH-1:0] = pat[2];
      3'd6: readdata[LED_WIDTH-1:0] = pat[3];
      default: readdata[3:0]        = {done, state == S_RUN, step};
    endcase
  end

endmodule

// File: tb/tb_wasca_led_sequencer.sv
// Directed bench for wasca_led_sequencer: pattern stepping, oneshot/DONE
// handling, live PERIOD change, CTRL priority, idle/static and async reset.
module tb_wasca_led_sequencer;

  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [LW-1:0] out_port;

  int n_chk  = 0;
  int n_fail = 0;

  wasca_led_sequencer #(.LED_WIDTH(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write lands on the next rising edge; returns 1ns after that edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rchk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    chk(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic ochk(input string tag, input logic [LW-1:0] exp);
    chk(tag, {{(32-LW){1'b0}}, out_port}, {{(32-LW){1'b0}}, exp});
  endtask

  logic [LW-1:0] exp27 [13] = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2,
                                4'h4, 4'h4, 4'h4, 4'h8, 4'h8, 4'h8, 4'h1};

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    ochk("rst_out", 4'h0);
    for (int a = 0; a < 8; a++) rchk($sformatf("rst_reg%0d", a), 3'(a), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Looping sequence, PERIOD=2, LAST=3
    wr(3'd3, 32'h1); wr(3'd4, 32'h2); wr(3'd5, 32'h4); wr(3'd6, 32'h8);
    wr(3'd1, 32'h2);
    wr(3'd0, 32'hD);
    ochk("seq_first_static", 4'h0);
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      ochk($sformatf("seq_out%0d", i), exp27[i]);
    end
    rchk("seq_status", 3'd7, 32'h4);
    rchk("seq_ctrl_rd", 3'd0, 32'hD);
    rchk("seq_period_rd", 3'd1, 32'h2);

    // Disable during RUN -> STATIC one clock later
    wr(3'd2, 32'hFFFF_FFF5);
    rchk("static_rd", 3'd2, 32'h5);
    wr(3'd0, 32'h0);
    ochk("dis_lag", 4'h1);
    @(posedge clk); #1;
    ochk("dis_static", 4'h5);
    rchk("dis_status", 3'd7, 32'h0);

    // Oneshot, PERIOD=0, LAST=1
    wr(3'd1, 32'h0);
    wr(3'd0, 32'h7);
    ochk("os_e0", 4'h5);
    @(posedge clk); #1; ochk("os_pat0", 4'h1);
    @(posedge clk); #1; ochk("os_pat1", 4'h2);
    @(posedge clk); #1; ochk("os_hold", 4'h2);
    rchk("os_status", 3'd7, 32'h9);
    wr(3'd7, 32'h8);
    rchk("os_clr", 3'd7, 32'h1);

    // DONE set coincides with clear: set wins
    wr(3'd0, 32'h3);
    wr(3'd7, 32'h8);
    rchk("setwins", 3'd7, 32'h8);
    wr(3'd7, 32'h7);
    rchk("clr_bit3_only", 3'd7, 32'h8);
    wr(3'd7, 32'h8);
    rchk("clr_again", 3'd7, 32'h0);

    // PERIOD shrunk mid-run
    wr(3'd1, 32'd100);
    wr(3'd0, 32'hD);
    repeat (49) @(posedge clk);
    wr(3'd1, 32'd10);
    rchk("per_before", 3'd7, 32'h4);
    @(posedge clk); #1;
    rchk("per_adv", 3'd7, 32'h5);
    @(posedge clk); #1;
    ochk("per_out", 4'h2);
    repeat (9) @(posedge clk);
    #1;
    rchk("per_dwell", 3'd7, 32'h5);
    @(posedge clk); #1;
    rchk("per_next", 3'd7, 32'h6);

    // CTRL write on a step boundary wins
    repeat (10) @(posedge clk);
    wr(3'd0, 32'hD);
    rchk("ctrl_prio", 3'd7, 32'h4);

    // Async reset mid-RUN
    @(posedge clk); #1;
    ochk("pre_rst_out", 4'h1);
    #2;
    reset = 1'b1;
    #1;
    ochk("async_rst_out", 4'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) rchk($sformatf("post_rst_reg%0d", a), 3'(a), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    ochk("post_rst_out", 4'h0);
    rchk("post_rst_idle", 3'd7, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wasca_led_sequencer.md
WASCA_LED_SEQUENCER -- requirements
Module: wasca_led_sequencer

Interface
REQ-001 SHALL have parameter LED_WIDTH, default 4, the width of out_port and of each pattern/static register.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port address  input  3  Avalon-MM word address.
REQ-005 SHALL have port chipselect  input  1  slave select.
REQ-006 SHALL have port write_n  input  1  active-low write strobe; write = chipselect && !write_n.
REQ-007 SHALL have port writedata  input  32  write data.
REQ-008 SHALL have port readdata  output  32  combinational read data, zero wait states, unused bits 0.
REQ-009 SHALL have port out_port  output  LED_WIDTH  registered LED drive.
REQ-010 SHALL operate on one clock, with reset asynchronous and active-high.

Function
REQ-011 SHALL implement register map: 0 CTRL {[3:2] LAST, [1] ONESHOT, [0] EN} rw; 1 PERIOD [23:0] rw; 2 STATIC [LED_WIDTH-1:0] rw; 3..6 PAT0..PAT3 [LED_WIDTH-1:0] rw; 7 STATUS {[3] DONE, [2] RUNNING, [1:0] STEP} read-only except DONE clear.
REQ-012 SHALL return register contents zero-extended on reads; reads have no side effects.
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL, on any CTRL write with writedata[0]=1, load step=0, counter=0, clear DONE, enter RUN (restart even if already RUN or DONE).
REQ-015 SHALL, on any CTRL write with writedata[0]=0, enter IDLE from any state; step and counter zeroed; DONE unchanged.
REQ-016 SHALL, in RUN, increment 24-bit counter each clock; when counter >= PERIOD: counter=0 and step advances.
REQ-017 SHALL advance step as: step >= LAST and ONESHOT=0 -> step=0; step >= LAST and ONESHOT=1 -> enter DONE, set DONE, hold step; else step+1.
REQ-018 SHALL give each step a dwell of PERIOD+1 clocks; PERIOD=0 gives one clock per step.
REQ-019 SHALL apply PERIOD, LAST and ONESHOT writes during RUN immediately (>= compares guarantee advance/wrap no later than next clock if new value is below current counter/step).
REQ-020 SHALL drive out_port, registered one clock after state/step: IDLE -> STATIC; RUN -> PAT[step]; DONE -> PAT[step].
REQ-021 SHALL reflect STATIC and PAT writes on out_port one clock after the write edge when that register is currently selected.
REQ-022 SHALL clear DONE on a write to address 7 with writedata[3]=1; other bits ignored; if clear and set coincide, set wins.
REQ-023 SHALL report RUNNING=1 only in RUN; STATUS.STEP = current step.
REQ-024 SHALL, when a CTRL write coincides with a step boundary, let the CTRL write take priority.

Reset
REQ-025 SHALL, while reset=1, force state=IDLE, all registers (CTRL, PERIOD, STATIC, PAT0..3, DONE, step, counter) to 0 and out_port to 0, independent of clk.
REQ-026 SHALL, on reset asserted mid-RUN, drop out_port to 0 immediately and remain IDLE after release until a CTRL write with EN=1.

Verification
REQ-027 SHALL be verified: reset, PAT0..3=1,2,4,8, PERIOD=2, CTRL=0xD (LAST=3, EN) -> out_port 1,1,1,2,2,2,4,4,4,8,8,8,1... starting one clock after the write.
REQ-028 SHALL be verified: PERIOD=0, LAST=1, ONESHOT=1, EN -> out_port PAT0 one clock, then PAT1 held; STATUS reads 0x9 (DONE, STEP=1); write 0x8 to address 7 -> STATUS 0x1.
REQ-029 SHALL be verified: RUN with PERIOD=100, counter near 50, write PERIOD=10 -> step advances on next clock, subsequent dwell 11 clocks.
REQ-030 SHALL be verified: STATIC=0x5, CTRL=0 during RUN -> out_port 0x5 one clock later, STATUS RUNNING=0.
REQ-031 SHALL be verified: reset pulse asserted between clock edges mid-RUN -> out_port 0 asynchronously; all registers read 0 after release.
